// File: rtl/peripheral_noc_router_output.sv
// NoC router output stage.
// Per VC: packet-granular round-robin arbitration across input ports feeding
// a registered FIFO of {last, flit}. Link side: flit-granular round-robin
// across VCs drives one shared flit/last bus with per-VC valid/ready.
module peripheral_noc_router_output #(
    parameter int FLIT_WIDTH   = 32,
    parameter int VCHANNELS    = 1,
    parameter int INPUTS       = 1,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [VCHANNELS-1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [VCHANNELS-1:0][INPUTS-1:0]                 in_last,
    input  logic [VCHANNELS-1:0][INPUTS-1:0]                 in_valid,
    output logic [VCHANNELS-1:0][INPUTS-1:0]                 in_ready,
    output logic [FLIT_WIDTH-1:0]                            out_flit,
    output logic                                             out_last,
    output logic [VCHANNELS-1:0]                             out_valid,
    input  logic [VCHANNELS-1:0]                             out_ready
);

    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int EW = FLIT_WIDTH + 1;

    // Per-VC signals shared with the link arbiter
    logic [VCHANNELS-1:0]         cand;
    logic [VCHANNELS-1:0]         pop;
    logic [VCHANNELS-1:0][EW-1:0] head;

    // Link arbiter state
    logic          sel_any;
    logic [VW-1:0] sel_idx;
    logic [VW-1:0] vcptr_q, vcptr_d;
    logic [EW-1:0] hold_q, hold_d;
    logic [EW-1:0] out_word;

    for (genvar gv = 0; gv < VCHANNELS; gv++) begin : g_vc
        logic          gnt_any;
        logic [IW-1:0] gnt_idx;
        logic          full;
        logic          empty;
        logic          push;
        logic          push_last;
        logic [EW-1:0] push_data;

        logic          lock_q, lock_d;
        logic [IW-1:0] lock_idx_q, lock_idx_d;
        logic [IW-1:0] ptr_q, ptr_d;

        logic [AW-1:0] rd_q, rd_d;
        logic [AW-1:0] wr_q, wr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [EW-1:0] mem_q [BUFFER_DEPTH];

        // Input grant: locked input only, otherwise first valid from ptr_q with wrap
        always_comb begin
            int unsigned j;
            j       = 0;
            gnt_any = 1'b0;
            gnt_idx = '0;
            if (lock_q) begin
                gnt_any = in_valid[gv][lock_idx_q];
                gnt_idx = lock_idx_q;
            end else begin
                for (int unsigned k = 0; k < INPUTS; k++) begin
                    j = {{(32-IW){1'b0}}, ptr_q} + k;
                    if (j >= INPUTS) begin
                        j = j - INPUTS;
                    end
                    if (!gnt_any && in_valid[gv][IW'(j)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = IW'(j);
                    end
                end
            end
        end

        for (genvar gi = 0; gi < INPUTS; gi++) begin : g_rdy
            assign in_ready[gv][gi] = !rst && gnt_any && !full && (gnt_idx == IW'(gi));
        end

        assign full      = (cnt_q == CW'(BUFFER_DEPTH));
        assign empty     = (cnt_q == '0);
        assign push      = gnt_any && !full;
        assign push_data = {in_last[gv][gnt_idx], in_flit[gv][gnt_idx]};
        assign push_last = push_data[EW-1];
        assign cand[gv]  = !empty && out_ready[gv];
        assign head[gv]  = mem_q[rd_q];

        // Lock and round-robin pointer update on each accepted flit
        always_comb begin
            lock_d     = lock_q;
            lock_idx_d = lock_idx_q;
            ptr_d      = ptr_q;
            if (push) begin
                if (push_last) begin
                    lock_d = 1'b0;
                    ptr_d  = (gnt_idx == IW'(INPUTS - 1)) ? '0 : gnt_idx + IW'(1);
                end else begin
                    lock_d     = 1'b1;
                    lock_idx_d = gnt_idx;
                end
            end
        end

        // FIFO pointer and occupancy update
        always_comb begin
            rd_d  = rd_q;
            wr_d  = wr_q;
            cnt_d = cnt_q;
            if (push) begin
                wr_d = (wr_q == AW'(BUFFER_DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
            if (pop[gv]) begin
                rd_d = (rd_q == AW'(BUFFER_DEPTH - 1)) ? '0 : rd_q + AW'(1);
            end
            if (push && !pop[gv]) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push && pop[gv]) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // Per-VC control state with asynchronous reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
                ptr_q      <= '0;
                rd_q       <= '0;
                wr_q       <= '0;
                cnt_q      <= '0;
            end else begin
                lock_q     <= lock_d;
                lock_idx_q <= lock_idx_d;
                ptr_q      <= ptr_d;
                rd_q       <= rd_d;
                wr_q       <= wr_d;
                cnt_q      <= cnt_d;
            end
        end

        // FIFO storage write; contents are don't-care until occupancy covers them
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_q] <= push_data;
            end
        end
    end

    // Link VC select: first ready, non-empty VC from vcptr_q with wrap
    always_comb begin
        int unsigned j;
        j       = 0;
        sel_any = 1'b0;
        sel_idx = '0;
        for (int unsigned k = 0; k < VCHANNELS; k++) begin
            j = {{(32-VW){1'b0}}, vcptr_q} + k;
            if (j >= VCHANNELS) begin
                j = j - VCHANNELS;
            end
            if (!sel_any && cand[VW'(j)]) begin
                sel_any = 1'b1;
                sel_idx = VW'(j);
            end
        end
    end

    // Link outputs, pop strobes and VC pointer advance
    always_comb begin
        pop = '0;
        if (sel_any) begin
            pop[sel_idx] = 1'b1;
        end
        out_valid = rst ? '0 : pop;
        out_word  = sel_any ? head[sel_idx] : hold_q;
        hold_d    = out_word;
        vcptr_d   = vcptr_q;
        if (sel_any) begin
            vcptr_d = (sel_idx == VW'(VCHANNELS - 1)) ? '0 : sel_idx + VW'(1);
        end
    end

    assign out_last = out_word[EW-1];
    assign out_flit = out_word[FLIT_WIDTH-1:0];

    // Link arbiter pointer and held output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcptr_q <= '0;
            hold_q  <= '0;
        end else begin
            vcptr_q <= vcptr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_peripheral_noc_router_output.sv
// Scoreboard bench for peripheral_noc_router_output (2 VCs, 2 inputs, depth 4).
// Stimulus pushes hand-computed expected link flits per VC; a negedge monitor
// pops and compares every flit the DUT presents.
module tb_peripheral_noc_router_output;

    localparam int FW = 32;
    localparam int NV = 2;
    localparam int NI = 2;
    localparam int BD = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NV-1:0][NI-1:0][FW-1:0] in_flit;
    logic [NV-1:0][NI-1:0]        in_last;
    logic [NV-1:0][NI-1:0]        in_valid;
    logic [NV-1:0][NI-1:0]        in_ready;
    logic [FW-1:0]                out_flit;
    logic                         out_last;
    logic [NV-1:0]                out_valid;
    logic [NV-1:0]                out_ready;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int trace_q[$];

    peripheral_noc_router_output #(
        .FLIT_WIDTH  (FW),
        .VCHANNELS   (NV),
        .INPUTS      (NI),
        .BUFFER_DEPTH(BD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input logic l, input logic [31:0] f);
        if (v == 0) exp_q0.push_back({l, f});
        else        exp_q1.push_back({l, f});
    endtask

    // Offer one flit and hold it until accepted (bounded)
    task automatic drive_flit(input int v, input int i, input logic [31:0] f, input logic l);
        int n;
        n = 0;
        in_flit[v][i]  = f;
        in_last[v][i]  = l;
        in_valid[v][i] = 1'b1;
        @(negedge clk);
        while (!in_ready[v][i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[v][i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: vc %0d in %0d flit 0x%0h got no in_ready expected in_ready=1", v, i, f);
        end else begin
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid[v][i] = 1'b0;
    endtask

    task automatic drive_pkt(input int v, input int i, input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            drive_flit(v, i, base + 32'(k), (k == len - 1));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        step();
    endtask

    // Monitor: every presented link flit is compared against the scoreboard
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (out_valid != '0) begin
            chk("out_valid_onehot", 64'($countones(out_valid)), 64'd1);
            for (int v = 0; v < NV; v++) begin
                if (out_valid[v]) begin
                    chk("out_valid_needs_ready", 64'(out_ready[v]), 64'd1);
                    trace_q.push_back(v);
                    if ((v == 0 && exp_q0.size() == 0) || (v == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_flit: vc %0d got 0x%0h last %0d expected no flit", v, out_flit, out_last);
                    end else begin
                        e = (v == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(v == 0 ? "link_flit_vc0" : "link_flit_vc1", 64'({out_last, out_flit}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic done0;
        logic bp_done;
        int   viol;
        int   n;

        // Reset state: in_ready/out_valid low even with a valid offer
        rst       = 1'b1;
        in_flit   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = '1;
        in_valid[0][0] = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        in_valid  = '0;
        out_ready = '0;
        step();
        rst = 1'b0;
        step();

        // Single flit, one-cycle latency
        out_ready = 2'b01;
        push_exp(0, 1'b1, 32'hA5A5_A5A5);
        in_flit[0][0]  = 32'hA5A5_A5A5;
        in_last[0][0]  = 1'b1;
        in_valid[0][0] = 1'b1;
        @(negedge clk);
        chk("t1_in_ready_offer", 64'(in_ready[0][0]), 64'd1);
        chk("t1_in_ready_other", 64'(in_ready[0][1]), 64'd0);
        chk("t1_out_valid_offer", 64'(out_valid), 64'd0);
        step();
        in_valid[0][0] = 1'b0;
        @(negedge clk);
        chk("t1_out_valid_next", 64'(out_valid), 64'd1);
        step();
        // Input 1 single flit brings the input pointer back to 0
        push_exp(0, 1'b1, 32'h0000_0001);
        drive_flit(0, 1, 32'h0000_0001, 1'b1);
        wait_drain("t1_drain");

        // Contention: input 0 packet first, input 1 held off until its last flit
        for (int k = 0; k < 3; k++) push_exp(0, (k == 2), 32'h10 + 32'(k));
        for (int k = 0; k < 3; k++) push_exp(0, (k == 2), 32'h20 + 32'(k));
        done0 = 1'b0;
        viol  = 0;
        fork
            begin
                drive_pkt(0, 0, 32'h10, 3);
                done0 = 1'b1;
            end
            drive_pkt(0, 1, 32'h20, 3);
            begin
                while (!done0) begin
                    @(negedge clk);
                    if (!done0 && in_ready[0][1]) viol++;
                end
            end
        join
        chk("t2_in1_blocked", 64'(viol), 64'd0);
        wait_drain("t2_drain");

        // Pointer at 1 after an input-0 packet: input 1 wins the tie
        push_exp(0, 1'b1, 32'h50);
        drive_flit(0, 0, 32'h50, 1'b1);
        wait_drain("t2b_single_drain");
        push_exp(0, 1'b0, 32'h68);
        push_exp(0, 1'b1, 32'h69);
        push_exp(0, 1'b0, 32'h60);
        push_exp(0, 1'b1, 32'h61);
        fork
            drive_pkt(0, 0, 32'h60, 2);
            drive_pkt(0, 1, 32'h68, 2);
        join
        wait_drain("t2b_drain");

        // Lock hold while the locked input idles
        push_exp(0, 1'b0, 32'h70);
        push_exp(0, 1'b1, 32'h71);
        push_exp(0, 1'b1, 32'h80);
        drive_flit(0, 0, 32'h70, 1'b0);
        in_flit[0][1]  = 32'h80;
        in_last[0][1]  = 1'b1;
        in_valid[0][1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_in1_locked_out", 64'(in_ready[0][1]), 64'd0);
        end
        step();
        drive_flit(0, 0, 32'h71, 1'b1);
        @(negedge clk);
        chk("t3_in1_granted_after", 64'(in_ready[0][1]), 64'd1);
        step();
        in_valid[0][1] = 1'b0;
        wait_drain("t3_drain");

        // Backpressure: 4 accepted into a full FIFO, rest after drain
        out_ready = 2'b00;
        acc_cnt   = 0;
        bp_done   = 1'b0;
        for (int k = 0; k < 6; k++) push_exp(0, (k == 5), 32'h90 + 32'(k));
        fork
            begin
                drive_pkt(0, 0, 32'h90, 6);
                bp_done = 1'b1;
            end
        join_none
        repeat (8) @(negedge clk);
        chk("t4_accepted_when_full", 64'(acc_cnt), 64'd4);
        chk("t4_in_ready_full", 64'(in_ready[0][0]), 64'd0);
        chk("t4_out_valid_blocked", 64'(out_valid), 64'd0);
        step();
        out_ready = 2'b01;
        n = 0;
        while (!bp_done && n < 300) begin
            step();
            n++;
        end
        chk("t4_stream_done", 64'(bp_done), 64'd1);
        chk("t4_accepted_all", 64'(acc_cnt), 64'd6);
        wait_drain("t4_drain");

        // VC interleave: last link transfer on VC1 leaves the VC pointer at 0
        out_ready = 2'b10;
        push_exp(1, 1'b1, 32'hBF);
        drive_flit(1, 0, 32'hBF, 1'b1);
        wait_drain("t5_prime_drain");
        out_ready = 2'b00;
        push_exp(0, 1'b0, 32'hA0);
        push_exp(0, 1'b1, 32'hA1);
        push_exp(1, 1'b0, 32'hB0);
        push_exp(1, 1'b1, 32'hB1);
        drive_flit(0, 0, 32'hA0, 1'b0);
        drive_flit(0, 0, 32'hA1, 1'b1);
        drive_flit(1, 0, 32'hB0, 1'b0);
        drive_flit(1, 0, 32'hB1, 1'b1);
        trace_q.delete();
        out_ready = 2'b11;
        wait_drain("t5_drain");
        chk("t5_trace_len", 64'(trace_q.size()), 64'd4);
        for (int k = 0; k < trace_q.size() && k < 4; k++) begin
            chk("t5_vc_order", 64'(trace_q[k]), 64'(k % 2));
        end

        // Only VC1 ready: VC0 never presented
        out_ready = 2'b00;
        push_exp(0, 1'b0, 32'hC0);
        push_exp(0, 1'b1, 32'hC1);
        push_exp(1, 1'b0, 32'hD0);
        push_exp(1, 1'b1, 32'hD1);
        drive_flit(0, 1, 32'hC0, 1'b0);
        drive_flit(0, 1, 32'hC1, 1'b1);
        drive_flit(1, 1, 32'hD0, 1'b0);
        drive_flit(1, 1, 32'hD1, 1'b1);
        trace_q.delete();
        out_ready = 2'b10;
        repeat (6) @(negedge clk);
        chk("t5b_trace_len", 64'(trace_q.size()), 64'd2);
        for (int k = 0; k < trace_q.size() && k < 2; k++) begin
            chk("t5b_only_vc1", 64'(trace_q[k]), 64'd1);
        end
        chk("t5b_vc0_held", 64'(out_valid), 64'd0);
        step();
        out_ready = 2'b11;
        wait_drain("t5b_drain");

        // Reset mid-packet with one flit queued
        out_ready = 2'b01;
        push_exp(0, 1'b0, 32'hE0);
        drive_flit(0, 0, 32'hE0, 1'b0);
        drive_flit(0, 0, 32'hE1, 1'b0);
        in_flit[0][0]  = 32'hE2;
        in_last[0][0]  = 1'b0;
        in_valid[0][0] = 1'b1;
        #1;
        chk("t6_queued_before_rst", 64'(out_valid), 64'd1);
        chk("t6_in_ready_before_rst", 64'(in_ready[0][0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        step();
        rst = 1'b0;
        push_exp(0, 1'b1, 32'hF0);
        in_flit[0][1]  = 32'hF0;
        in_last[0][1]  = 1'b1;
        in_valid[0][1] = 1'b1;
        @(negedge clk);
        chk("t6_in1_granted_first", 64'(in_ready[0][1]), 64'd1);
        chk("t6_fifo_empty", 64'(out_valid), 64'd0);
        step();
        in_valid[0][1] = 1'b0;
        wait_drain("t6_drain");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
